// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud divider helper, frame-bit constants.
package uart_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam logic        START_BIT  = 1'b0;
   localparam logic        STOP_BIT   = 1'b1;
   localparam logic        IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } rx_state_e;

   // Clocks per oversample tick, never below 1.
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned os);
      int unsigned d;
      d = clk_hz / (baud * os);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO with registered head output; push and pop may coincide even when full.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid,
   output logic             o_full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;

   logic             w_do_pop;
   logic             w_do_push;
   logic [CW-1:0]    w_count_n;
   logic [AW-1:0]    w_rd_n;
   logic [WIDTH-1:0] w_head_n;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_dout  = r_dout;
   assign o_valid = r_valid;

   always_comb begin
      w_do_pop  = i_pop & (r_count != '0);
      w_do_push = i_push & (~o_full | w_do_pop);
      w_count_n = r_count + CW'(w_do_push) - CW'(w_do_pop);
      w_rd_n    = r_rd + AW'(w_do_pop);
      w_head_n  = r_dout;
      // The incoming byte becomes head directly when it lands in the slot being exposed.
      if (w_count_n != '0) begin
         if (w_do_push && (r_wr == w_rd_n)) w_head_n = i_din;
         else                                w_head_n = r_mem[w_rd_n];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr] <= i_din;
            r_wr        <= r_wr + AW'(1);
         end
         r_rd    <= w_rd_n;
         r_count <= w_count_n;
         r_dout  <= w_head_n;
         r_valid <= (w_count_n != '0);
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with output FIFO.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OS         = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   input  logic       i_rd,
   output logic [7:0] o_data_out,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_parity_err
);

   localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OS);
   localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned OW  = $clog2(OS);
   localparam logic [OW-1:0] OS_HALF = OW'(OS / 2 - 1);
   localparam logic [OW-1:0] OS_LAST = OW'(OS - 1);

   logic [1:0]    r_sync;
   logic [TW-1:0] r_tick_cnt;
   rx_state_e     r_state;
   logic [OW-1:0] r_os_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_push;
   logic          r_frame_err;
   logic          r_overrun;
   logic          w_rx_s;
   logic          w_tick;
   logic          w_full;
   logic          w_pop;
   logic          w_par_bad;

   assign w_rx_s = r_sync[1];
   assign w_tick = (r_tick_cnt == TW'(DIV - 1));
   assign w_pop  = i_rd & o_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync     <= {2{IDLE_LEVEL}};
         r_tick_cnt <= '0;
      end else begin
         r_sync     <= {r_sync[0], i_rx};
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_parity_err;
   logic r_par_bad;
   assign w_par_bad    = r_par_bad;
   assign o_parity_err = r_parity_err;
`else
   assign w_par_bad    = 1'b0;
   assign o_parity_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_os_cnt    <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
         r_par_bad    <= 1'b0;
`endif
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         if (w_tick) begin
            unique case (r_state)
               StIdle: begin
                  if (w_rx_s == START_BIT) begin
                     r_state  <= StStart;
                     r_os_cnt <= '0;
                  end
               end
               StStart: begin
                  if (r_os_cnt == OS_HALF) begin
                     r_os_cnt  <= '0;
                     r_bit_cnt <= '0;
                     r_state   <= (w_rx_s == START_BIT) ? StData : StIdle;
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
               StData: begin
                  if (r_os_cnt == OS_LAST) begin
                     r_os_cnt  <= '0;
                     r_shift   <= {w_rx_s, r_shift[7:1]};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                     if (r_bit_cnt == 3'(DATA_BITS - 1)) r_state <= StParity;
`else
                     if (r_bit_cnt == 3'(DATA_BITS - 1)) r_state <= StStop;
`endif
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               StParity: begin
                  if (r_os_cnt == OS_LAST) begin
                     r_os_cnt     <= '0;
                     r_par_bad    <= ^{r_shift, w_rx_s};
                     r_parity_err <= ^{r_shift, w_rx_s};
                     r_state      <= StStop;
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
`endif
               StStop: begin
                  if (r_os_cnt == OS_LAST) begin
                     r_os_cnt <= '0;
                     // A parity failure already reported this frame; stay silent here.
                     if (w_rx_s == STOP_BIT) begin
                        r_state <= StIdle;
                        r_push  <= ~w_par_bad;
                     end else begin
                        r_state     <= StBreak;
                        r_frame_err <= ~w_par_bad;
                     end
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
               StBreak: begin
                  if (w_rx_s == IDLE_LEVEL) r_state <= StIdle;
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_overrun <= 1'b0;
      else       r_overrun <= r_push & w_full & ~w_pop;
   end

   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (r_push),
      .i_din   (r_shift),
      .i_pop   (w_pop),
      .o_dout  (o_data_out),
      .o_valid (o_valid),
      .o_full  (w_full)
   );

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 16 clocks per bit (DIV=1); parity steps need UART_RX_PARITY_EN.
module tb_uart_rx_os;

   localparam int BIT_CLKS = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rd;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rise_cyc = 0;
   int fe_cnt  = 0;
   int ov_cnt  = 0;
   int pe_cnt  = 0;
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   uart_rx_os #(
      .CLK_HZ     (1843200),
      .BAUD       (115200),
      .OS         (16),
      .FIFO_DEPTH (4)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx         (rx),
      .i_rd         (rd),
      .o_data_out   (data_out),
      .o_valid      (valid),
      .o_frame_err  (frame_err),
      .o_overrun    (overrun),
      .o_parity_err (parity_err)
   );

   // Cycle counter, valid-rise timestamp and error-pulse tallies.
   always @(posedge clk) begin
      cyc        <= cyc + 1;
      prev_valid <= valid;
      if (valid && !prev_valid) rise_cyc <= cyc;
      if (frame_err)  fe_cnt <= fe_cnt + 1;
      if (overrun)    ov_cnt <= ov_cnt + 1;
      if (parity_err) pe_cnt <= pe_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop();
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
   endtask

   // One frame; rst_bit >= 0 pulses reset mid-way through that data bit.
   // A zero stop bit leaves the line low on return.
   task automatic send_frame(input logic [7:0] b, input logic par_flip,
                             input logic stop_val, input int rst_bit);
      rx = 1'b0;
      tick(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == rst_bit) begin
            tick(8);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            tick(BIT_CLKS - 9);
         end else begin
            tick(BIT_CLKS);
         end
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip;
      tick(BIT_CLKS);
`else
      if (par_flip) rx = 1'b1;
`endif
      rx = stop_val;
      tick(BIT_CLKS);
      if (stop_val) tick(2 * BIT_CLKS);
   endtask

   initial begin
      int t0;
      rst = 1'b1;
      rx  = 1'b1;
      rd  = 1'b0;
      tick(3);
      check("rst_valid", valid, 0);
      check("rst_data", data_out, 8'h00);
      check("rst_pulses", {frame_err, overrun, parity_err}, 0);
      rst = 1'b0;
      tick(4);

      // Single byte and its latency from the start edge.
      t0 = cyc;
      send_frame(8'hA5, 1'b0, 1'b1, -1);
      check("a5_latency_window", ((rise_cyc - t0) >= 150) && ((rise_cyc - t0) <= 170), 1);
      check("a5_valid", valid, 1);
      check("a5_data", data_out, 8'hA5);
      check("a5_pulses", fe_cnt + ov_cnt + pe_cnt, 0);
      pop();
      check("a5_popped_valid", valid, 0);

      // Fill the FIFO, then overflow it.
      send_frame(8'h01, 1'b0, 1'b1, -1);
      send_frame(8'h02, 1'b0, 1'b1, -1);
      send_frame(8'h03, 1'b0, 1'b1, -1);
      send_frame(8'h04, 1'b0, 1'b1, -1);
      check("fill_no_overrun", ov_cnt, 0);
      check("fill_head", data_out, 8'h01);
      send_frame(8'h55, 1'b0, 1'b1, -1);
      check("overrun_once", ov_cnt, 1);
      check("overrun_other_pulses", fe_cnt + pe_cnt, 0);
      for (int i = 1; i <= 4; i++) begin
         check("drain_valid", valid, 1);
         check("drain_data", data_out, 32'(i));
         pop();
      end
      check("drain_empty", valid, 0);

      // Framing error, held break, then recovery.
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      tick(40 * BIT_CLKS);
      check("frame_err_once", fe_cnt, 1);
      check("frame_err_nothing_pushed", valid, 0);
      rx = 1'b1;
      tick(2 * BIT_CLKS);
      check("break_no_retrigger", fe_cnt, 1);
      send_frame(8'h7E, 1'b0, 1'b1, -1);
      check("after_break_valid", valid, 1);
      check("after_break_data", data_out, 8'h7E);
      pop();
      check("after_break_empty", valid, 0);

      // Short glitch on the idle line.
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(3 * BIT_CLKS);
      check("glitch_valid", valid, 0);
      check("glitch_pulses", {fe_cnt[7:0], ov_cnt[7:0], pe_cnt[7:0]}, {8'd1, 8'd1, 8'd0});

      // Reset mid-frame, then a clean byte.
      send_frame(8'hFF, 1'b0, 1'b1, 4);
      check("midrst_valid", valid, 0);
      send_frame(8'h81, 1'b0, 1'b1, -1);
      check("midrst_next_valid", valid, 1);
      check("midrst_next_data", data_out, 8'h81);
      pop();
      check("midrst_empty", valid, 0);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h03, 1'b1, 1'b1, -1);
      check("parity_bad_pulse", pe_cnt, 1);
      check("parity_bad_dropped", valid, 0);
      check("parity_bad_no_frame_err", fe_cnt, 1);
      send_frame(8'h03, 1'b0, 1'b1, -1);
      check("parity_good_valid", valid, 1);
      check("parity_good_data", data_out, 8'h03);
      check("parity_good_no_pulse", pe_cnt, 1);
      pop();
`else
      check("parity_tied_low", pe_cnt, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
